// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: one ld/sd in flight, response strobe LATENCY cycles after accept.
// Backpressure: req_ready only in IDLE; stall freezes the pipeline from the accept cycle until the response cycle.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int CW = $clog2(LATENCY) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [63:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;
  logic [63:0]   mem_q [DEPTH];

  logic          op_write;
  logic [63:0]   op_addr;
  logic [63:0]   op_wdata;
  logic [60:0]   op_index;
  logic          op_err;
  logic [IW-1:0] mem_idx;
  logic          complete;
  logic          mem_we;

  // With LATENCY==1 the accept edge is also the completion edge, so operands come straight from the request.
  always_comb begin
    op_write = (state_q == IDLE) ? req_write : write_q;
    op_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    op_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    op_index = op_addr[63:3];
    op_err   = (op_addr[2:0] != 3'b000) || ({3'b000, op_index} >= 64'(DEPTH));
    mem_idx  = op_index[IW-1:0];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    complete     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            complete = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == CW'(1)) begin
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (complete) begin
      state_d      = RESP;
      cnt_d        = '0;
      resp_err_d   = op_err;
      resp_rdata_d = (!op_write && !op_err) ? mem_q[mem_idx] : 64'd0;
    end

    mem_we = complete && op_write && !op_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Array contents survive reset; a reset on the completion edge suppresses the store.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_idx] <= op_wdata;
    end
  end

  assign req_ready  = rst || (state_q == IDLE);
  assign stall      = !rst && (((state_q == IDLE) && req_valid) || (state_q == WAIT));
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: instances with LATENCY 2, 1 and 4, scoreboarded responses.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid  [3];
  logic        req_write  [3];
  logic [63:0] req_addr   [3];
  logic [63:0] req_wdata  [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic [63:0] resp_rdata [3];
  logic        resp_err   [3];
  logic        stall      [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH  (256),
      .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 4))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_ready (req_ready[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g]),
      .stall     (stall[g])
    );
  end

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  typedef struct {
    int          k;
    int          due;
    logic [63:0] rd;
    logic        err;
  } exp_t;

  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] rd;
    logic        err;
  } vec_t;

  exp_t sb[$];
  int   nerr = 0;
  int   nchk = 0;
  int   cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (resp_valid[k] === 1'b1) begin
        if (sb.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_resp: inst %0d got resp_valid=1 expected 0 (cycle %0d)", k, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_inst", 64'(k), 64'(e.k));
          chk("resp_cycle", 64'(cyc), 64'(e.due));
          chk("resp_rdata", resp_rdata[k], e.rd);
          chk("resp_err", 64'(resp_err[k]), 64'(e.err));
        end
      end
    end
  end

  // Called just after a falling edge with instance k idle; returns just after a falling edge, idle again.
  task automatic do_req(int k, logic w, logic [63:0] a, logic [63:0] d, logic [63:0] rd, logic e);
    int   ns;
    exp_t x;
    req_valid[k] = 1'b1;
    req_write[k] = w;
    req_addr[k]  = a;
    req_wdata[k] = d;
    #1;
    chk("ready_idle", 64'(req_ready[k]), 64'd1);
    chk("stall_accept", 64'(stall[k]), 64'd1);
    x.k = k; x.due = cyc + lat_of(k); x.rd = rd; x.err = e;
    sb.push_back(x);
    @(negedge clk);
    req_valid[k] = 1'b0;
    req_write[k] = ~w;
    req_addr[k]  = 64'h0000_0000_0000_0BAD;
    req_wdata[k] = '1;
    #1;
    ns = 1;
    for (int i = 0; i < 20 && resp_valid[k] !== 1'b1; i++) begin
      if (stall[k] === 1'b1) ns++;
      chk("ready_wait", 64'(req_ready[k]), 64'd0);
      @(negedge clk);
      #1;
    end
    if (resp_valid[k] !== 1'b1) begin
      nchk++;
      nerr++;
      $display("FAIL resp_timeout: inst %0d got no resp_valid expected one", k);
    end
    chk("stall_cycles", 64'(ns), 64'(lat_of(k)));
    chk("stall_resp", 64'(stall[k]), 64'd0);
    chk("ready_resp", 64'(req_ready[k]), 64'd0);
    @(negedge clk);
    #1;
    chk("valid_drop", 64'(resp_valid[k]), 64'd0);
    chk("rdata_drop", resp_rdata[k], 64'd0);
    chk("err_drop", 64'(resp_err[k]), 64'd0);
    chk("ready_back", 64'(req_ready[k]), 64'd1);
  endtask

  vec_t tv [12];

  initial begin
    tv[0]  = '{1'b1, 64'h10,                  64'hDEAD_BEEF_CAFE_F00D, 64'h0,                   1'b0};
    tv[1]  = '{1'b0, 64'h10,                  64'h0,                   64'hDEAD_BEEF_CAFE_F00D, 1'b0};
    tv[2]  = '{1'b0, 64'h13,                  64'h0,                   64'h0,                   1'b1};
    tv[3]  = '{1'b0, 64'h800,                 64'h0,                   64'h0,                   1'b1};
    tv[4]  = '{1'b0, 64'h18,                  64'h0,                   64'h0,                   1'b0};
    tv[5]  = '{1'b1, 64'h7F8,                 64'hA5A5,                64'h0,                   1'b0};
    tv[6]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1234,                64'h0,                   1'b1};
    tv[7]  = '{1'b1, 64'h14,                  64'h77,                  64'h0,                   1'b1};
    tv[8]  = '{1'b0, 64'h10,                  64'h0,                   64'hDEAD_BEEF_CAFE_F00D, 1'b0};
    tv[9]  = '{1'b0, 64'h7F8,                 64'h0,                   64'hA5A5,                1'b0};
    tv[10] = '{1'b1, 64'h10,                  64'h55,                  64'h0,                   1'b0};
    tv[11] = '{1'b0, 64'h10,                  64'h0,                   64'h55,                  1'b0};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
    end
    repeat (2) @(negedge clk);
    req_valid[0] = 1'b1;
    #1;
    chk("rst_ready", 64'(req_ready[0]), 64'd1);
    chk("rst_stall", 64'(stall[0]), 64'd0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("idle_ready", 64'(req_ready[0]), 64'd1);
      chk("idle_stall", 64'(stall[0]), 64'd0);
      chk("idle_valid", 64'(resp_valid[0]), 64'd0);
      chk("idle_rdata", resp_rdata[0], 64'd0);
    end

    for (int i = 0; i < 12; i++) begin
      do_req(0, tv[i].w, tv[i].a, tv[i].d, tv[i].rd, tv[i].err);
    end

    // req_valid held high: accepts every 3 cycles, alternating 0x0 / 0x8.
    begin
      int   last;
      int   nacc;
      logic tog;
      exp_t x;
      last = -100; nacc = 0; tog = 1'b0;
      req_valid[0] = 1'b1;
      req_write[0] = 1'b0;
      #1;
      for (int b = 0; b < 40; b++) begin
        if (nacc == 4 && req_ready[0] === 1'b1) break;
        chk("b2b_ready", 64'(req_ready[0]), 64'((cyc - last) >= 3));
        chk("b2b_stall", 64'(stall[0]), 64'((cyc - last) != 2));
        if (req_ready[0] === 1'b1) begin
          if (last >= 0) chk("b2b_spacing", 64'(cyc - last), 64'd3);
          last = cyc;
          nacc++;
          req_addr[0] = tog ? 64'h8 : 64'h0;
          tog = ~tog;
          x.k = 0; x.due = cyc + 2; x.rd = 64'h0; x.err = 1'b0;
          sb.push_back(x);
        end
        @(negedge clk);
        #1;
      end
      req_valid[0] = 1'b0;
      chk("b2b_accepts", 64'(nacc), 64'd4);
    end

    // Reset while the store waits: no response, no write.
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 64'h20; req_wdata[0] = 64'd5;
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    chk("abort_wait_stall", 64'(stall[0]), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_rst_stall", 64'(stall[0]), 64'd0);
    chk("abort_rst_ready", 64'(req_ready[0]), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("abort_no_resp", 64'(resp_valid[0]), 64'd0);
    end
    do_req(0, 1'b0, 64'h20, 64'h0, 64'h0, 1'b0);

    do_req(1, 1'b1, 64'h8, 64'h1111_2222_3333_4444, 64'h0, 1'b0);
    do_req(1, 1'b0, 64'h8, 64'h0, 64'h1111_2222_3333_4444, 1'b0);
    do_req(1, 1'b0, 64'h4, 64'h0, 64'h0, 1'b1);
    do_req(2, 1'b1, 64'h8, 64'h9999_8888_7777_6666, 64'h0, 1'b0);
    do_req(2, 1'b0, 64'h8, 64'h0, 64'h9999_8888_7777_6666, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
